// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
// State encoding plus parameter-derived register widths.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_REL,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int cnt_width(input int hold, input int gap, input int tmo);
        int w;
        w = $clog2(max3(hold, gap, tmo) + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after STAGES clock edges.
// Output is active low and safe to use as a synchronous hold.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign rst_no = sync_q[STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: releases CH_NUM resets in order, each gated by the
// previous channel's ready handshake, with a per-channel watchdog.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             soft_rst,
    input  logic [CH_NUM-1:0]                ch_ready,
    output logic [CH_NUM-1:0]                ch_rst,
    output logic                             all_done,
    output logic                             fault,
    output logic [idx_width(CH_NUM)-1:0]     fault_ch
);

    localparam int CNT_W = cnt_width(HOLD_CYC, GAP_CYC, TIMEOUT_CYC);
    localparam int IDX_W = idx_width(CH_NUM);
    localparam bit WDOG_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC);
    localparam logic [CNT_W-1:0] TO_END   = CNT_W'(WDOG_EN ? TIMEOUT_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_NUM - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CH_NUM-1:0]  ch_rst_q, ch_rst_d;
    logic               all_done_q, all_done_d;
    logic               fault_q, fault_d;
    logic [IDX_W-1:0]   fault_ch_q, fault_ch_d;
    logic               sync_rst_n;
    logic               clr;
    logic               ready_cur;
    logic [CH_NUM-1:0]  idx_onehot;

    rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .rst_no (sync_rst_n)
    );

    // Until the synchronizer releases, behave exactly like a soft restart.
    assign clr = soft_rst | ~sync_rst_n;

    always_comb begin
        idx_onehot = '0;
        ready_cur  = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (idx_q == IDX_W'(i)) begin
                idx_onehot[i] = 1'b1;
                ready_cur     = ch_ready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            ch_rst_q   <= '1;
            all_done_q <= 1'b0;
            fault_q    <= 1'b0;
            fault_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            ch_rst_q   <= ch_rst_d;
            all_done_q <= all_done_d;
            fault_q    <= fault_d;
            fault_ch_q <= fault_ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        unique case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_END) state_d = ST_REL;
            end
            ST_REL: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_cur) begin
                    state_d = (idx_q == IDX_LAST) ? ST_DONE : ST_GAP;
                end else if (WDOG_EN && cnt_q == TO_END) begin
                    state_d = ST_FAULT;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_END) begin
                    state_d = ST_REL;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
        if (state_d != state_q) cnt_d = '0;
        if (clr) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    always_comb begin
        ch_rst_d   = ch_rst_q;
        all_done_d = 1'b0;
        fault_d    = 1'b0;
        fault_ch_d = fault_ch_q;
        unique case (state_q)
            ST_REL:   ch_rst_d = ch_rst_q & ~idx_onehot;
            ST_DONE:  all_done_d = 1'b1;
            ST_FAULT: begin
                ch_rst_d   = '1;
                fault_d    = 1'b1;
                fault_ch_d = idx_q;
            end
            default: ;
        endcase
        if (clr) begin
            ch_rst_d   = '1;
            all_done_d = 1'b0;
            fault_d    = 1'b0;
            fault_ch_d = '0;
        end
    end

    assign ch_rst   = ch_rst_q;
    assign all_done = all_done_q;
    assign fault    = fault_q;
    assign fault_ch = fault_ch_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: a 4-channel instance with a short
// watchdog and a 1-channel corner instance with ready tied high.
module tb_rst_seq_gen;

    localparam int MODE_FULL = 0;
    localparam int MODE_SOFT = 1;
    localparam int MODE_TO   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       soft_rst;
    logic [3:0] ch_ready;

    logic [3:0] a_rst;
    logic       a_done;
    logic       a_fault;
    logic [1:0] a_fch;

    logic       b_rst;
    logic       b_done;
    logic       b_fault;
    logic       b_fch;

    int n_chk  = 0;
    int n_pass = 0;
    bit b_fault_seen = 1'b0;

    always #5 clk = ~clk;

    rst_seq_gen #(
        .CH_NUM      (4),
        .SYNC_STAGES (2),
        .HOLD_CYC    (4),
        .GAP_CYC     (2),
        .TIMEOUT_CYC (20)
    ) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .soft_rst (soft_rst),
        .ch_ready (ch_ready),
        .ch_rst   (a_rst),
        .all_done (a_done),
        .fault    (a_fault),
        .fault_ch (a_fch)
    );

    rst_seq_gen #(
        .CH_NUM      (1),
        .SYNC_STAGES (2),
        .HOLD_CYC    (4),
        .GAP_CYC     (0),
        .TIMEOUT_CYC (0)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .soft_rst (soft_rst),
        .ch_ready (1'b1),
        .ch_rst   (b_rst),
        .all_done (b_done),
        .fault    (b_fault),
        .fault_ch (b_fch)
    );

    always @(posedge clk) begin
        if (b_fault !== 1'b0) b_fault_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic soft_pulse(input string tag);
        soft_rst = 1'b1;
        ch_ready = '0;
        tick();
        soft_rst = 1'b0;
        check({tag, "_rst"}, a_rst, 4'hF);
        check({tag, "_fault"}, a_fault, 1'b0);
        check({tag, "_done"}, a_done, 1'b0);
        check({tag, "_b_done"}, b_done, 1'b0);
    endtask

    // Cycle c counts edges from E0 (or from the soft_rst sampling edge).
    task automatic run_seq(input int mode);
        int last;
        bit full;
        bit tmo;
        full = (mode == MODE_FULL);
        tmo  = (mode == MODE_TO);
        last = full ? 45 : (tmo ? 50 : 17);
        for (int c = 1; c <= last; c++) begin
            tick();
            case (c)
                4:  check("hold_end", a_rst, 4'hF);
                5:  check("rel0", a_rst, 4'hE);
                6:  check("b_wait", b_done, 1'b0);
                7: begin
                    check("b_done", b_done, 1'b1);
                    check("b_rst", b_rst, 1'b0);
                end
                10: ch_ready[0] = 1'b1;
                14: check("gap0", a_rst, 4'hE);
                15: check("rel1", a_rst, 4'hC);
                17: check("wait1", a_rst, 4'hC);
                20: ch_ready[1] = 1'b1;
                24: check("gap1", a_rst, 4'hC);
                25: check("rel2", a_rst, 4'h8);
                30: if (full) ch_ready[2] = 1'b1;
                34: if (full) check("gap2", a_rst, 4'h8);
                35: if (full) check("rel3", a_rst, 4'h0);
                40: if (full) ch_ready[3] = 1'b1;
                41: if (full) check("done_early", a_done, 1'b0);
                42: if (full) begin
                    check("done", a_done, 1'b1);
                    check("done_fault", a_fault, 1'b0);
                end
                43: if (full) ch_ready[0] = 1'b0;
                45: begin
                    if (full) begin
                        check("rdy_drop_rst", a_rst, 4'h0);
                        check("rdy_drop_done", a_done, 1'b1);
                    end
                    if (tmo) begin
                        check("pre_fault", a_fault, 1'b0);
                        check("pre_fault_rst", a_rst, 4'h8);
                    end
                end
                46: if (tmo) begin
                    check("fault", a_fault, 1'b1);
                    check("fault_ch", a_fch, 2'd2);
                    check("fault_rst", a_rst, 4'hF);
                    check("fault_done", a_done, 1'b0);
                end
                50: if (tmo) begin
                    check("fault_hold", a_fault, 1'b1);
                    check("fault_hold_rst", a_rst, 4'hF);
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        soft_rst = 1'b0;
        ch_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rst", a_rst, 4'hF);
        check("rst_done", a_done, 1'b0);
        check("rst_fault", a_fault, 1'b0);
        check("rst_fch", a_fch, 2'd0);
        check("rst_b_rst", b_rst, 1'b1);
        rst_n = 1'b1;
        tick();
        check("sync_hold", a_rst, 4'hF);
        tick();
        run_seq(MODE_FULL);

        #3 rst_n = 1'b0;
        #1;
        check("arst_rst", a_rst, 4'hF);
        check("arst_done", a_done, 1'b0);
        check("arst_b_done", b_done, 1'b0);
        check("arst_b_rst", b_rst, 1'b1);
        ch_ready = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tick();
        run_seq(MODE_FULL);

        soft_pulse("soft_done");
        run_seq(MODE_SOFT);
        soft_pulse("soft_wait");
        run_seq(MODE_TO);
        soft_pulse("soft_fault");
        check("soft_fault_fch", a_fch, 2'd0);
        repeat (5) tick();
        check("restart_rel0", a_rst, 4'hE);
        check("b_no_fault", b_fault_seen, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rst_seq_gen.md
# rst_seq_gen

Synthesizable, parametrised reset sequencer: the hardware successor to the team's fixed-delay testbench clock/reset generator. Takes one asynchronous active-low system reset and releases CH_NUM downstream active-high reset outputs in order, one per channel. Each release waits for that channel's ready handshake plus a programmable gap. A per-channel timeout watchdog replaces the bench's fixed-time termination. Sits at the top of every multi-block design, between the board reset pin and the subsystem resets.

## Interface
- CH_NUM, 4: number of sequenced reset channels, ≥1.
- SYNC_STAGES, 2: reset-release synchronizer depth, ≥2.
- HOLD_CYC, 4: cycles all channels stay in reset after synchronized release, ≥1.
- GAP_CYC, 2: extra cycles between channel i ready and channel i+1 release, ≥0.
- TIMEOUT_CYC, 10000: max cycles to wait for a channel's ready; 0 disables the watchdog.
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous assert, active low.
- soft_rst  input  1  synchronous restart request, level/pulse, active high.
- ch_ready  input  CH_NUM  per-channel "out of reset and alive" handshake.
- ch_rst  output  CH_NUM  per-channel reset, active high.
- all_done  output  1  all channels released and ready.
- fault  output  1  watchdog expired.
- fault_ch  output  max(1,$clog2(CH_NUM))  channel index that timed out.

## Operation
- Reset values, asynchronous on rst_n=0: ch_rst all 1, all_done 0, fault 0, fault_ch 0, state HOLD, channel index 0, counter 0.
- FSM states:
  - HOLD: count HOLD_CYC cycles, then go to REL.
  - REL: one cycle; clear ch_rst[idx]; go to WAIT.
  - WAIT: count cycles. When ch_ready[idx] is sampled 1:
    - if idx is the last channel, go to DONE;
    - otherwise go to GAP.
  - WAIT timeout: if TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC without ready, go to FAULT.
  - GAP: count GAP_CYC cycles, increment idx, go to REL. With GAP_CYC=0, GAP lasts exactly one cycle.
  - DONE: all_done=1. Stays in DONE.
  - FAULT: fault=1, fault_ch=idx, all ch_rst re-asserted to 1. Stays in FAULT.
- soft_rst=1 in any state: next edge gives HOLD, all ch_rst=1, all_done=0, fault=0, idx=0, counter=0.
- Priorities:
  - soft_rst beats everything.
  - In WAIT, ready beats timeout on the same cycle.
- Released channels stay released if their ready later drops. ch_ready is only watched for the current idx.
- A channel whose ready is already 1 at release still passes through WAIT for one cycle.
- Counter width is $clog2(max(HOLD_CYC,GAP_CYC,TIMEOUT_CYC)+1). The counter clears on every state change and never wraps.

## Timing
- Reset assertion: rst_n low forces all outputs to reset values immediately, with no clock edge needed.
- Reset release: the synchronizer output deasserts SYNC_STAGES rising edges after rst_n rises. Call that edge E0.
- ch_rst[0] falls HOLD_CYC+1 edges after E0 (HOLD count plus the REL register).
- If ch_ready[i] is sampled high at edge T, then ch_rst[i+1] falls at T+GAP_CYC+2.
- If the last channel's ready is sampled at T, all_done rises at T+1.
- Timeout: fault rises TIMEOUT_CYC+1 edges after the ch_rst[idx] release edge. ch_rst is re-asserted on the same edge.
- soft_rst: sampled at edge S; effects are visible after S; the HOLD count restarts from S.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package rst_seq_pkg: FSM state encoding (HOLD, REL, WAIT, GAP, DONE, FAULT) and a clog2/max helper function for width derivation.
- Sub-module rst_sync: a SYNC_STAGES-deep async-assert / sync-release flop chain. It is the only consumer of rst_n besides the async clear of the FSM registers, and is reusable elsewhere.
- Top level: FSM, one shared counter, idx register, output registers.

## Test plan
- Nominal, defaults: rst_n low for 3 cycles then high; each ch_ready[i] is driven high 5 cycles after ch_rst[i] falls.
  - Expect ch_rst[0] low at E0+5, channels falling in order 0..3, each release spaced by the ready delay plus GAP timing.
  - Expect all_done high one cycle after ch_ready[3] is sampled.
- Timeout, TIMEOUT_CYC=20: ch_ready[2] is never driven.
  - Expect fault=1 and fault_ch=2 at release+21.
  - Expect all ch_rst=1 and all_done=0.
  - Expect the state held until soft_rst.
- soft_rst mid-sequence: pulse soft_rst while waiting on channel 1.
  - Expect all ch_rst=1 and fault=0 next cycle.
  - Expect ch_rst[0] to fall HOLD_CYC+1 cycles after the pulse.
- Async reset in DONE: drop rst_n between clock edges.
  - Expect ch_rst all 1 and all_done 0 immediately, without a clock edge.
  - Release rst_n and expect the full sequence to repeat.
- Corner parameters, CH_NUM=1, GAP_CYC=0, TIMEOUT_CYC=0, ready tied high:
  - Expect all_done at E0+HOLD_CYC+3.
  - Expect no fault ever.
  - Expect fault_ch width 1.
